// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial transmitter.
// The optional parity slot is enabled with SERIAL_TX_PARITY_EN.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/shift_reg_load_en.sv
// Parallel-load shift register with shift enable and direction.
// Load wins over shift; reset clears it.
module shift_reg_load_en #(
  parameter int DATA_W    = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_shift) begin
      if (LSB_FIRST) r_q <= r_q >> 1;
      else           r_q <= r_q << 1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_tx_4.sv
// Framed parallel-in serial-out transmitter with valid/ready intake.
// Define SERIAL_TX_PARITY_EN to add an even-parity bit before STOP.
module serial_tx_4
  import serial_tx_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_d,
  output logic              o_ready,
  output logic              o_ser,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_t r_state;
  tx_state_t w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0] w_q;
  logic w_accept;
  logic w_last;
  logic w_shift;

  assign w_accept = i_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_shift  = (r_state == DATA);

  shift_reg_load_en #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_sreg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_d     (i_d),
    .o_q     (w_q)
  );

`ifdef SERIAL_TX_PARITY_EN
  logic r_par;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)      r_par <= 1'b0;
    else if (w_accept) r_par <= ^i_d;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DATA && !w_last) r_cnt <= r_cnt + CNT_W'(1);
      else                            r_cnt <= '0;
    end
  end

  always_comb begin
    w_next  = r_state;
    o_ser   = IDLE_LEVEL;
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_next = START;
      end
      START: begin
        o_ser  = START_LEVEL;
        o_busy = 1'b1;
        w_next = DATA;
      end
      DATA: begin
        o_ser  = LSB_FIRST ? w_q[0] : w_q[DATA_W-1];
        o_busy = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
        if (w_last) w_next = PARITY;
`else
        if (w_last) w_next = STOP;
`endif
      end
      PARITY: begin
`ifdef SERIAL_TX_PARITY_EN
        o_ser  = r_par;
        o_busy = 1'b1;
        w_next = STOP;
`else
        w_next = IDLE;
`endif
      end
      STOP: begin
        o_ser  = STOP_LEVEL;
        o_busy = 1'b1;
        o_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: doc/serial_tx_4.md
Name: serial_tx_4

Overview:
- Parallel-in, serial-out transmitter: the sending end of the team's 4-bit serial link.
- Accepts a DATA_W-bit word through a valid/ready handshake, then frames it and shifts it out one bit per clock on a single line.
- Sits between the enable-loaded 4-bit registers on the producer side and the serial receiver in the lab datapath.

Parameters:
- DATA_W, 4: number of data bits per frame (legal values 2..8).
- LSB_FIRST, 1: 1 shifts bit 0 first; 0 shifts bit DATA_W-1 first.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_valid  input  1  producer offers i_d this cycle.
- i_d  input  DATA_W  word to transmit.
- o_ready  output  1  transmitter can accept a word this cycle.
- o_ser  output  1  serial line; idle level is 1.
- o_busy  output  1  frame in progress.
- o_done  output  1  one-cycle pulse while the last frame bit is driven.

Behaviour:
- Reset: one clock, synchronous, active-low; i_rst_n sampled low at a rising edge of i_clk. After that edge: state IDLE, o_ser=1, o_ready=1, o_busy=0, o_done=0, shift register and bit counter cleared.
- All outputs are decoded from registered state. No combinational path from i_valid or i_d to any output.
- States:
  - IDLE: o_ready=1, o_ser=1.
  - START: o_ser=0.
  - DATA: o_ser=current shift bit.
  - STOP: o_ser=1, o_done=1.
  - o_busy=1 in START, DATA and STOP.
- Accept: at an edge with i_valid=1, o_ready=1 and i_rst_n=1, i_d is loaded into the shift register and the state goes to START.
- Latency: the start bit appears on o_ser in the cycle after acceptance.
- Transitions:
  - START -> DATA after 1 cycle.
  - DATA lasts exactly DATA_W cycles; bit counter runs 0..DATA_W-1, then -> STOP.
  - STOP -> IDLE after 1 cycle.
- Frame length: DATA_W+2 cycles. Minimum accept-to-accept period: DATA_W+3 cycles, because the next word is accepted in the IDLE cycle after STOP.
- Shift order:
  - LSB_FIRST=1: o_ser=sreg[0]; shift right each DATA cycle.
  - LSB_FIRST=0: o_ser=sreg[DATA_W-1]; shift left each DATA cycle.
- i_valid while o_ready=0 is ignored. i_d changes after acceptance do not affect the frame in flight.
- Reset mid-frame aborts the frame immediately: o_ser=1 on the next cycle, no o_done pulse, and the word is lost.
- i_valid asserted in the same cycle as reset: no acceptance.
- Bit counter width is clog2(DATA_W); it does not wrap outside DATA.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: state PARITY inserted between DATA and STOP. o_ser = even parity (XOR of all DATA_W bits of the accepted word). Parity is computed at accept time and held in a register. Frame becomes DATA_W+3 cycles; o_done still pulses in STOP.
- Undefined: no PARITY state and no parity register; behaviour as above.

Decomposition:
- Package serial_tx_pkg:
  - state enum typedef tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - constants IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- One sub-module: shift_reg_load_en. DATA_W-wide register with parallel load, shift enable and a direction parameter, built from the existing enable flip-flops. The FSM and bit counter stay in serial_tx_4.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with i_valid=1, i_d=4'hF -> o_ser=1, o_ready=1, o_busy=0, o_done=0, no frame starts.
- Basic frame, LSB_FIRST=1: i_d=4'b1011 accepted -> o_ser over the next 6 cycles = 0,1,1,0,1,1; o_done high only in cycle 6; o_ready=1 in cycle 7.
- MSB first: LSB_FIRST=0, i_d=4'b1011 -> o_ser = 0,1,0,1,1,1.
- Busy ignore and back-to-back: i_valid held with i_d=4'h3 during a frame, changed to 4'hC mid-frame -> first frame carries 4'h3; 4'hC is accepted in the IDLE cycle after STOP; start bits are 7 cycles apart.
- Reset mid-frame: i_rst_n=0 during the 2nd data bit -> next cycle o_ser=1, o_busy=0, o_ready=1; no o_done pulse.
- Parity, with SERIAL_TX_PARITY_EN defined: i_d=4'b0111 -> o_ser = 0,1,1,1,0,1,1 (parity bit=1); o_done in cycle 7.
